// File: rtl/vga_console_master.sv
// Byte-stream to VGA text-buffer Wishbone writer: owns the text cursor, writes
// character/colour planes and handles LF, CR, BS and FF (screen clear).
//   state    | meaning
//   IDLE     | ready for next character
//   WR_CHAR  | write character plane at cursor
//   GAP1     | bus idle between character and colour writes
//   WR_COL   | write colour plane at cursor, then advance cursor
//   CLR_CHAR | clear: write 0x20 to character plane at clear index
//   GAP2     | clear: bus idle between planes
//   CLR_COL  | clear: write latched colour to colour plane
//   GAP3     | clear: bus idle, step to next cell or finish
module vga_console_master #(
    parameter int TEXT_WIDTH  = 80,
    parameter int TEXT_HEIGHT = 60,
    parameter int ACK_TIMEOUT = 3
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [7:0]  char_data,
    input  logic [7:0]  char_colour,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [14:0] ADR_O,
    output logic [7:0]  DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);

    localparam int CELLS = TEXT_WIDTH * TEXT_HEIGHT;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WR_CHAR, GAP1, WR_COL, CLR_CHAR, GAP2, CLR_COL, GAP3
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     x_q, x_d;
    logic [5:0]     y_q, y_d;
    logic [7:0]     char_q, char_d;
    logic [7:0]     colour_q, colour_d;
    logic [12:0]    clr_q, clr_d;
    logic [TW-1:0]  tmr_q, tmr_d;

    logic           strobe, term;
    logic [12:0]    cell_idx;
    logic [5:0]     y_inc;
    logic [14:0]    adr;
    logic [7:0]     dat;

    assign cell_idx = 13'(y_q) * 13'(TEXT_WIDTH) + 13'(x_q);
    assign y_inc    = (y_q == 6'(TEXT_HEIGHT - 1)) ? 6'd0 : y_q + 6'd1;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        char_d   = char_q;
        colour_d = colour_q;
        clr_d    = clr_q;
        adr      = '0;
        dat      = '0;
        strobe   = (state_q == WR_CHAR) || (state_q == WR_COL) ||
                   (state_q == CLR_CHAR) || (state_q == CLR_COL);
        term     = strobe && (ACK_I || (tmr_q == '0));
        // Timer reloads whenever the strobe is low; strobes are always separated by a low cycle.
        tmr_d    = strobe ? (term ? TMR_LOAD : tmr_q - TW'(1)) : TMR_LOAD;

        case (state_q)
            IDLE: begin
                if (char_valid) begin
                    char_d   = char_data;
                    colour_d = char_colour;
                    if (char_data >= 8'h20) begin
                        state_d = WR_CHAR;
                    end else begin
                        case (char_data)
                            8'h0A: begin
                                x_d = '0;
                                y_d = y_inc;
                            end
                            8'h0D: x_d = '0;
                            8'h08: begin
                                if (x_q != '0) begin
                                    x_d = x_q - 7'd1;
                                end else if (y_q != '0) begin
                                    x_d = 7'(TEXT_WIDTH - 1);
                                    y_d = y_q - 6'd1;
                                end
                            end
                            8'h0C: begin
                                clr_d   = '0;
                                state_d = CLR_CHAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WR_CHAR: begin
                adr = {2'b01, cell_idx};
                dat = char_q;
                if (term) state_d = GAP1;
            end
            GAP1: state_d = WR_COL;
            WR_COL: begin
                adr = {2'b10, cell_idx};
                dat = colour_q;
                if (term) begin
                    state_d = IDLE;
                    if (x_q == 7'(TEXT_WIDTH - 1)) begin
                        x_d = '0;
                        y_d = y_inc;
                    end else begin
                        x_d = x_q + 7'd1;
                    end
                end
            end
            CLR_CHAR: begin
                adr = {2'b01, clr_q};
                dat = 8'h20;
                if (term) state_d = GAP2;
            end
            GAP2: state_d = CLR_COL;
            CLR_COL: begin
                adr = {2'b10, clr_q};
                dat = colour_q;
                if (term) state_d = GAP3;
            end
            GAP3: begin
                if (clr_q == 13'(CELLS - 1)) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = IDLE;
                end else begin
                    clr_d   = clr_q + 13'd1;
                    state_d = CLR_CHAR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            char_q   <= '0;
            colour_q <= '0;
            clr_q    <= '0;
            tmr_q    <= TMR_LOAD;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            char_q   <= char_d;
            colour_q <= colour_d;
            clr_q    <= clr_d;
            tmr_q    <= tmr_d;
        end
    end

    // Bus controls decode straight from the state flop so reset drops them asynchronously.
    assign STB_O      = strobe;
    assign CYC_O      = strobe;
    assign WE_O       = strobe;
    assign ADR_O      = adr;
    assign DAT_O      = dat;
    assign char_ready = (state_q == IDLE) && RST_I;
    assign busy       = (state_q != IDLE);
    assign cursor_x   = x_q;
    assign cursor_y   = y_q;

endmodule

// File: tb/tb_vga_console_master.sv
// Scoreboard bench for vga_console_master: expected Wishbone writes are queued
// by the stimulus and popped by an independent bus monitor.
module tb_vga_console_master;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [7:0]  char_data = '0;
    logic [7:0]  char_colour = '0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [14:0] ADR_O;
    logic [7:0]  DAT_O;
    logic        CYC_O, STB_O, WE_O;
    logic        ACK_I;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;
    logic        ack_tie = 1'b1;

    assign ACK_I = ack_tie & STB_O;

    always #5 CLK_I = ~CLK_I;

    vga_console_master dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .char_data(char_data), .char_colour(char_colour),
        .char_valid(char_valid), .char_ready(char_ready),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
        .WE_O(WE_O), .ACK_I(ACK_I),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    typedef struct {
        logic [14:0] adr;
        logic [7:0]  dat;
        int          len;
        int          gap;
    } xfer_t;

    xfer_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int mx = 0;
    int my = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void push_x(logic [14:0] a, logic [7:0] d, int l, int g);
        xfer_t e;
        e.adr = a;
        e.dat = d;
        e.len = l;
        e.gap = g;
        exp_q.push_back(e);
    endfunction

    // Bus monitor: every STB_O pulse must match the head of the queue.
    initial begin : monitor
        logic        prev_stb;
        int          low_run;
        int          len;
        logic [14:0] st_adr;
        logic [7:0]  st_dat;
        xfer_t       cur;
        logic        have_cur;
        prev_stb = 1'b0;
        low_run  = 0;
        len      = 0;
        st_adr   = '0;
        st_dat   = '0;
        have_cur = 1'b0;
        forever begin
            @(negedge CLK_I);
            chk("cyc_we_follow_stb", {30'd0, CYC_O, WE_O}, {30'd0, STB_O, STB_O});
            if (STB_O && !prev_stb) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_xfer actual adr=%0h dat=%0h required=none", ADR_O, DAT_O);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("xfer_adr", 32'(ADR_O), 32'(cur.adr));
                    chk("xfer_dat", 32'(DAT_O), 32'(cur.dat));
                    if (cur.gap >= 0) chk("xfer_gap", low_run, cur.gap);
                end
                st_adr = ADR_O;
                st_dat = DAT_O;
                len = 1;
            end else if (STB_O) begin
                len++;
                chk("adr_stable", 32'(ADR_O), 32'(st_adr));
                chk("dat_stable", 32'(DAT_O), 32'(st_dat));
            end else if (prev_stb && have_cur) begin
                chk("xfer_len", len, cur.len);
                have_cur = 1'b0;
            end
            if (STB_O) low_run = 0;
            else low_run++;
            prev_stb = STB_O;
        end
    end

    // Offers one character; n = negedges from accept until char_ready, b = busy cycles.
    task automatic send(input logic [7:0] ch, input logic [7:0] col, output int n, output int b);
        int k;
        k = 0;
        while (!char_ready && k < 40000) begin
            @(negedge CLK_I);
            k++;
        end
        char_data   = ch;
        char_colour = col;
        char_valid  = 1'b1;
        @(posedge CLK_I);
        #1 char_valid = 1'b0;
        n = 0;
        b = 0;
        do begin
            @(negedge CLK_I);
            n++;
            if (busy) b++;
        end while (!char_ready && n < 40000);
    endtask

    task automatic send_print(input logic [7:0] ch, input logic [7:0] col, output int n);
        int idx, l, b;
        idx = my * 80 + mx;
        l = ack_tie ? 1 : 3;
        push_x(15'h2000 + 15'(idx), ch, l, -1);
        push_x(15'h4000 + 15'(idx), col, l, 1);
        send(ch, col, n, b);
        if (mx == 79) begin
            mx = 0;
            my = (my == 59) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    task automatic send_ctrl(input logic [7:0] ch, output int n);
        int b;
        send(ch, 8'h00, n, b);
    endtask

    task automatic chk_cursor(string name, int x, int y);
        chk({name, "_x"}, 32'(cursor_x), x);
        chk({name, "_y"}, 32'(cursor_y), y);
    endtask

    initial begin : stim
        int n, b, k;
        logic found;

        repeat (3) @(negedge CLK_I);
        chk("rst_bus", {29'd0, CYC_O, STB_O, WE_O}, 0);
        chk("rst_adr", 32'(ADR_O), 0);
        chk("rst_dat", 32'(DAT_O), 0);
        chk_cursor("rst_cursor", 0, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(char_ready), 0);
        RST_I = 1'b1;
        @(negedge CLK_I);
        chk("ready_after_rst", 32'(char_ready), 1);

        // Printable char with immediate ACK
        send_print(8'h41, 8'h1F, n);
        chk("ready_latency_ack", n, 4);
        chk_cursor("after_A", 1, 0);

        // No ACK: each strobe times out after 3 cycles
        ack_tie = 1'b0;
        send_print(8'h42, 8'h33, n);
        chk("ready_latency_timeout", n, 8);
        chk_cursor("after_B", 2, 0);
        ack_tie = 1'b1;

        send_ctrl(8'h0D, n);
        chk("ctrl_latency", n, 1);
        chk_cursor("cr_row0", 0, 0);

        for (int i = 0; i < 59; i++) send_ctrl(8'h0A, n);
        chk_cursor("lf59", 0, 59);
        mx = 0; my = 59;
        for (int i = 0; i < 5; i++) send_print(8'h61 + 8'(i), 8'h02, n);
        chk_cursor("at_5_59", 5, 59);
        send_ctrl(8'h0A, n);
        chk_cursor("lf_wrap", 0, 0);

        for (int i = 0; i < 3; i++) send_ctrl(8'h0A, n);
        mx = 0; my = 3;
        for (int i = 0; i < 7; i++) send_print(8'h30 + 8'(i), 8'h04, n);
        chk_cursor("at_7_3", 7, 3);
        send_ctrl(8'h0D, n);
        chk_cursor("cr", 0, 3);

        for (int i = 0; i < 58; i++) send_ctrl(8'h0A, n);
        chk_cursor("lf_to_row1", 0, 1);
        send_ctrl(8'h08, n);
        chk_cursor("bs_row_up", 79, 0);
        send_ctrl(8'h0D, n);
        send_ctrl(8'h08, n);
        chk_cursor("bs_origin", 0, 0);
        send_ctrl(8'h01, n);
        chk("ignored_latency", n, 1);
        chk_cursor("ignored_code", 0, 0);

        // Fill to the last cell, then write it
        for (int i = 0; i < 59; i++) send_ctrl(8'h0A, n);
        mx = 0; my = 59;
        for (int i = 0; i < 79; i++) send_print(8'h2E, 8'h05, n);
        chk_cursor("at_last_cell", 79, 59);
        push_x(15'h32BF, 8'h5A, 1, -1);
        push_x(15'h52BF, 8'h0E, 1, 1);
        send(8'h5A, 8'h0E, n, b);
        chk_cursor("last_cell_wrap", 0, 0);
        mx = 0; my = 0;

        // Full screen clear
        send_print(8'h43, 8'h01, n);
        chk_cursor("before_ff", 1, 0);
        for (int i = 0; i < 4800; i++) begin
            push_x(15'h2000 + 15'(i), 8'h20, 1, (i == 0) ? -1 : 1);
            push_x(15'h4000 + 15'(i), 8'h07, 1, 1);
        end
        send(8'h0C, 8'h07, n, b);
        chk("ff_busy_cycles", b, 19200);
        chk_cursor("after_ff", 0, 0);
        chk("ff_queue_drained", exp_q.size(), 0);
        mx = 0; my = 0;

        // Reset during the 10th clear cell
        send_print(8'h44, 8'h01, n);
        for (int i = 0; i < 10; i++) begin
            push_x(15'h2000 + 15'(i), 8'h20, 1, (i == 0) ? -1 : 1);
            if (i < 9) push_x(15'h4000 + 15'(i), 8'h07, 1, 1);
        end
        char_data   = 8'h0C;
        char_colour = 8'h07;
        char_valid  = 1'b1;
        @(posedge CLK_I);
        #1 char_valid = 1'b0;
        found = 1'b0;
        k = 0;
        while (!found && k < 200) begin
            @(negedge CLK_I);
            k++;
            if (STB_O && ADR_O == 15'h2009) found = 1'b1;
        end
        chk("cell10_reached", 32'(found), 1);
        #2 RST_I = 1'b0;
        #1;
        chk("rst_async_stb_cyc", {30'd0, STB_O, CYC_O}, 0);
        repeat (2) @(negedge CLK_I);
        chk_cursor("mid_rst_cursor", 0, 0);
        chk("mid_rst_ready", 32'(char_ready), 0);
        RST_I = 1'b1;
        @(negedge CLK_I);
        chk("post_rst_ready", 32'(char_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        chk_cursor("post_rst_cursor", 0, 0);
        repeat (30) @(negedge CLK_I);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_console_master.md
# vga_console_master

Wishbone initiator that turns a byte stream of characters into write transfers against the VGA text-mode buffer (80x60 cells). It owns a text cursor, writes each printable character to the character plane and its colour attribute to the colour plane, and interprets a small set of control codes (LF, CR, BS, FF). It sits between a character source (CPU-side FIFO or UART receiver) and the VGA text buffer's Wishbone target port.

## Interface
- TEXT_WIDTH, 80, columns per row
- TEXT_HEIGHT, 60, rows per screen
- ACK_TIMEOUT, 3, maximum cycles STB_O stays high waiting for ACK_I; must be ≥1
- CLK_I  in  1  system clock
- RST_I  in  1  reset; asynchronous, active-low
- char_data  in  8  character code
- char_colour  in  8  colour attribute sampled with char_data
- char_valid  in  1  char_data/char_colour valid
- char_ready  out  1  block can accept a character this cycle
- ADR_O  out  15  Wishbone address
- DAT_O  out  8  Wishbone write data
- CYC_O  out  1  Wishbone cycle
- STB_O  out  1  Wishbone strobe
- WE_O  out  1  Wishbone write enable; always equal to STB_O
- ACK_I  in  1  Wishbone acknowledge
- cursor_x  out  7  current column
- cursor_y  out  6  current row
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Cell index = cursor_y*TEXT_WIDTH + cursor_x, 13 bits. Character plane address = {2'b01, index}; colour plane address = {2'b10, index}.
- States: IDLE, WR_CHAR, GAP1, WR_COL, CLR_CHAR, GAP2, CLR_COL, GAP3.
- IDLE: char_ready=1. Handshake on char_valid & char_ready latches char_data and char_colour.
- Printable (any code except 0x08, 0x0A, 0x0C, 0x0D, and other 0x00-0x1F): IDLE -> WR_CHAR (DAT_O=char) -> GAP1 -> WR_COL (DAT_O=colour) -> IDLE. On WR_COL termination, the cursor advances: x+1; at x=TEXT_WIDTH-1, x=0 and y+1; at the last cell it wraps to (0,0).
- 0x0A LF: x=0, y+1, wrapping y to 0 at TEXT_HEIGHT. 0x0D CR: x=0. 0x08 BS: x-1; at x=0, y>0 goes to (TEXT_WIDTH-1, y-1); at (0,0) no change. These complete in one cycle with no bus activity, and the FSM stays in IDLE.
- Other codes 0x00-0x1F are accepted and ignored.
- 0x0C FF: a clear counter runs from 0 to TEXT_WIDTH*TEXT_HEIGHT-1. For each cell: CLR_CHAR (DAT_O=0x20) -> GAP2 -> CLR_COL (DAT_O=latched colour) -> GAP3, then the next cell. After the last cell: cursor=(0,0), return to IDLE.
- Transfer rule:
  - CYC_O, STB_O and WE_O rise together.
  - ADR_O and DAT_O are stable while STB_O is high.
  - The transfer terminates at the first edge where ACK_I=1, or when STB_O has been high for ACK_TIMEOUT cycles, whichever comes first.
  - CYC_O, STB_O and WE_O drop on the cycle after termination. Gap states keep them low for exactly one cycle.

## Timing
- Reset (asserted, async): CYC_O=STB_O=WE_O=0, ADR_O=0, DAT_O=0, cursor=(0,0), busy=0, char_ready=0 while RST_I is low. After release, state is IDLE and char_ready=1.
- Reset mid-transfer: bus strobes drop immediately (async), the FSM returns to IDLE, the cursor goes to (0,0), and any in-progress clear is abandoned.
- Printable char with ACK_I high in the first cycle:
  - accept at edge 0; STB_O high in cycle 1 (char); low in cycle 2; high in cycle 3 (colour).
  - Cursor updates at edge 4; char_ready is high from cycle 4. That is 4 cycles per character.
- With ACK_I never asserted: each STB_O pulse lasts ACK_TIMEOUT cycles, for 2*ACK_TIMEOUT+2 cycles per character.
- FF with first-cycle ACK: 4*TEXT_WIDTH*TEXT_HEIGHT cycles (19200 by default). char_ready stays low throughout.
- char_ready is 0 in every state except IDLE. A char_valid held high is not consumed until char_ready=1.
- cursor_x and cursor_y are registered and change only at the edges defined above.

## Test plan
- Reset, then send 0x41 with colour 0x1F, ACK_I tied to STB_O -> transfers ADR_O=0x2000/DAT_O=0x41, then 0x4000/0x1F, one idle cycle between them; cursor=(1,0); char_ready back high 4 cycles after accept.
- ACK_I tied 0, ACK_TIMEOUT=3, send 0x42 -> each STB_O pulse lasts exactly 3 cycles with a 1-cycle gap; cursor advances; no hang.
- Cursor at (79,59), send 0x5A -> writes at 0x32BF and 0x52BF; cursor wraps to (0,0).
- Control codes:
  - LF at (5,59) -> (0,0).
  - CR at (7,3) -> (0,3).
  - BS at (0,1) -> (79,0); BS at (0,0) -> (0,0).
  - 0x01 -> no change.
  - None of these produce STB_O activity.
- FF with colour 0x07 -> 9600 writes: 0x2000..0x32BF with data 0x20 interleaved with 0x4000..0x52BF with data 0x07, in ascending cell order; busy high for 19200 cycles; final cursor=(0,0).
- Drive RST_I low during the STB_O of the 10th FF cell -> STB_O and CYC_O drop without waiting for a clock; after release, cursor=(0,0), char_ready=1, no further bus activity.
